// File: rtl/ultrasound_range_meter.sv
// Ultrasound range meter: fires a trigger pulse, times the sensor echo and
// reports the distance in units as a 9-bit signed value (always 0..255).
// Optional build macro RANGE_AVERAGE_EN: report the mean of the last four results.
module ultrasound_range_meter #(
   parameter int unsigned CYCLES_PER_UNIT = 3996,
   parameter int unsigned TRIG_CYCLES     = 270,
   parameter int unsigned WAIT_CYCLES     = 27000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       echo,
   output logic       trigger,
   output logic [8:0] r,
   output logic       r_valid,
   output logic       busy,
   output logic       timeout
);

   localparam int unsigned SUB_W   = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
   localparam int unsigned CNT_MAX = (TRIG_CYCLES > WAIT_CYCLES) ? TRIG_CYCLES : WAIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned UNIT_W  = 8;

   localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(CYCLES_PER_UNIT - 1);
   localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST    = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [UNIT_W-1:0] UNIT_SAT     = UNIT_W'(255);
   localparam logic [UNIT_W-1:0] UNIT_PRE_SAT = UNIT_W'(254);
   // Counter values after counting the rising-edge cycle itself
   localparam logic [SUB_W-1:0]  SUB_FIRST    = (CYCLES_PER_UNIT > 1) ? SUB_W'(1) : SUB_W'(0);
   localparam logic [UNIT_W-1:0] UNIT_FIRST   = (CYCLES_PER_UNIT > 1) ? UNIT_W'(0) : UNIT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      TRIGGER,
      WAIT_ECHO,
      MEASURE,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [UNIT_W-1:0]   unit_q, unit_d;
   logic                echo_m, echo_s, echo_d;
   logic                echo_rise;
   logic                timeout_d;
   logic                load_c;
   logic [UNIT_W-1:0]   result_c;
   logic [UNIT_W-1:0]   filt_c;

   // Two-flop synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise = echo_s & ~echo_d;

   // Next-state, counter and strobe decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sub_d     = sub_q;
      unit_d    = unit_q;
      timeout_d = 1'b0;
      load_c    = 1'b0;
      result_c  = unit_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) state_d = TRIGGER;
         end
         TRIGGER: begin
            if (cnt_q == TRIG_LAST) begin
               state_d = WAIT_ECHO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_ECHO: begin
            if (echo_rise) begin
               // Clear the counters and count this first high cycle
               state_d = MEASURE;
               sub_d   = SUB_FIRST;
               unit_d  = UNIT_FIRST;
            end else if (cnt_q == WAIT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         MEASURE: begin
            if (echo_s) begin
               if (sub_q == SUB_LAST) begin
                  sub_d  = '0;
                  unit_d = unit_q + UNIT_W'(1);
                  if (unit_q == UNIT_PRE_SAT) begin
                     // Out of range: report full scale without waiting for the fall
                     state_d  = DONE;
                     load_c   = 1'b1;
                     result_c = UNIT_SAT;
                  end
               end else begin
                  sub_d = sub_q + SUB_W'(1);
               end
            end else begin
               state_d  = DONE;
               load_c   = 1'b1;
               result_c = unit_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef RANGE_AVERAGE_EN
   // Four-result window: the newest result plus the three previous ones
   logic [UNIT_W-1:0] hist_q [3];
   logic              hist_valid_q;
   logic [UNIT_W+1:0] sum_c;

   // Moving average of the window; the first result stands for all four
   always_comb begin
      sum_c  = (UNIT_W+2)'(result_c) + (UNIT_W+2)'(hist_q[0]) +
               (UNIT_W+2)'(hist_q[1]) + (UNIT_W+2)'(hist_q[2]);
      filt_c = hist_valid_q ? sum_c[UNIT_W+1:2] : result_c;
   end

   // History shift register, preloaded with the first result after reset
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) hist_q[i] <= '0;
         hist_valid_q <= 1'b0;
      end else if (load_c) begin
         if (hist_valid_q) begin
            hist_q[2] <= hist_q[1];
            hist_q[1] <= hist_q[0];
            hist_q[0] <= result_c;
         end else begin
            for (int i = 0; i < 3; i++) hist_q[i] <= result_c;
         end
         hist_valid_q <= 1'b1;
      end
   end
`else
   // Report the latest result directly
   always_comb begin
      filt_c = result_c;
   end
`endif

   // State, counters and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sub_q   <= '0;
         unit_q  <= '0;
         trigger <= 1'b0;
         busy    <= 1'b0;
         r_valid <= 1'b0;
         timeout <= 1'b0;
         r       <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         unit_q  <= unit_d;
         trigger <= (state_d == TRIGGER);
         busy    <= (state_d != IDLE);
         r_valid <= load_c;
         timeout <= timeout_d;
         if (load_c) r <= {1'b0, filt_c};
      end
   end

endmodule
